// File: rtl/d_flip_flop_pkg.sv
// Shared defaults for the d_flip_flop register chain.
package d_flip_flop_pkg;
    localparam int DFF_DEFAULT_N      = 9;
    localparam int DFF_DEFAULT_STAGES = 1;
endpackage

// File: rtl/d_flip_flop_if.sv
// Data/enable bundle for d_flip_flop; master drives en/d, slave returns q.
interface d_flip_flop_if
    import d_flip_flop_pkg::*;
#(
    parameter int N = DFF_DEFAULT_N
) ();
    logic         en;
    logic [N-1:0] d;
    logic [N-1:0] q;

    modport master (output en, output d, input q);
    modport slave  (input en, input d, output q);
endinterface

// File: rtl/dff_stage.sv
// One N-bit register stage; reset takes priority over enable.
module dff_stage
    import d_flip_flop_pkg::*;
#(
    parameter int           N       = DFF_DEFAULT_N,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [N-1:0] data_d;
    logic [N-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (rst) begin
            data_d = RST_VAL;
        end else if (en) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/d_flip_flop.sv
// Parameterised D flip-flop: STAGES cascaded N-bit registers with shared
// synchronous reset and stage-advance enable; q comes straight from the last stage.
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int           N       = DFF_DEFAULT_N,
    parameter int           STAGES  = DFF_DEFAULT_STAGES,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    if (N < 1) begin : g_bad_n
        $error("d_flip_flop: N must be >= 1");
    end
    if (STAGES < 1) begin : g_bad_stages
        $error("d_flip_flop: STAGES must be >= 1");
    end

    // chain[0] is the input; chain[k] is the output of stage k.
    logic [N-1:0] chain [0:STAGES];

    assign chain[0] = d;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        dff_stage #(
            .N       (N),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (chain[k]),
            .q   (chain[k+1])
        );
    end

    assign q = chain[STAGES];
endmodule

// File: tb/tb_d_flip_flop.sv
// Directed bench for d_flip_flop: single-stage table plus 3-stage corner sequences.
module tb_d_flip_flop;
    logic clk;
    logic rst1;
    logic rst3;

    d_flip_flop_if #(.N(9)) if1 ();
    d_flip_flop_if #(.N(9)) if3 ();

    d_flip_flop #(.N(9), .STAGES(1), .RST_VAL(9'h000)) dut1 (
        .clk (clk),
        .rst (rst1),
        .en  (if1.en),
        .d   (if1.d),
        .q   (if1.q)
    );

    d_flip_flop #(.N(9), .STAGES(3), .RST_VAL(9'h0AA)) dut3 (
        .clk (clk),
        .rst (rst3),
        .en  (if3.en),
        .d   (if3.d),
        .q   (if3.q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [8:0] d;
        logic [8:0] exp_q;
        string      name;
    } vec_t;

    vec_t vecs [11];
    int   n_vec;
    int   n_err;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: q=%h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, take one rising edge, settle past it.
    task automatic step1(input logic r, input logic e, input logic [8:0] dv);
        rst1   = r;
        if1.en = e;
        if1.d  = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic r, input logic e, input logic [8:0] dv);
        rst3   = r;
        if3.en = e;
        if3.d  = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst1 = 1'b1; if1.en = 1'b1; if1.d = 9'h000;
        rst3 = 1'b1; if3.en = 1'b0; if3.d = 9'h000;

        vecs[0]  = '{1'b1, 1'b1, 9'h000, 9'h000, "reset_edge"};
        vecs[1]  = '{1'b0, 1'b1, 9'h1A3, 9'h1A3, "first_capture"};
        vecs[2]  = '{1'b0, 1'b1, 9'h055, 9'h055, "seq_055"};
        vecs[3]  = '{1'b0, 1'b1, 9'h0F0, 9'h0F0, "seq_0F0"};
        vecs[4]  = '{1'b1, 1'b1, 9'h0F0, 9'h000, "midstream_reset"};
        vecs[5]  = '{1'b0, 1'b1, 9'h1E1, 9'h1E1, "post_reset_1E1"};
        vecs[6]  = '{1'b0, 1'b1, 9'h055, 9'h055, "load_055"};
        vecs[7]  = '{1'b0, 1'b0, 9'h1FF, 9'h055, "en0_hold_a"};
        vecs[8]  = '{1'b0, 1'b0, 9'h1FF, 9'h055, "en0_hold_b"};
        vecs[9]  = '{1'b0, 1'b1, 9'h1FF, 9'h1FF, "en1_resume"};
        vecs[10] = '{1'b1, 1'b0, 9'h1A3, 9'h000, "reset_over_en0"};

        #2;
        for (int i = 0; i < 11; i++) begin
            step1(vecs[i].rst, vecs[i].en, vecs[i].d);
            check(vecs[i].name, if1.q, vecs[i].exp_q);
        end

        // Load a known value, then pulse rst between edges with en=0.
        step1(1'b0, 1'b1, 9'h1E1);
        check("s1_load_1E1", if1.q, 9'h1E1);
        if1.en = 1'b0;
        #1 rst1 = 1'b1;
        #1 check("s1_rst_pulse_mid", if1.q, 9'h1E1);
        #1 rst1 = 1'b0;
        @(posedge clk);
        #1 check("s1_rst_pulse_after_edge", if1.q, 9'h1E1);

        // d changes between edges: no combinational path, only the edge value counts.
        if1.en = 1'b1;
        if1.d  = 9'h0AA;
        #1 check("s1_no_comb_path_a", if1.q, 9'h1E1);
        if1.d  = 9'h155;
        #1 check("s1_no_comb_path_b", if1.q, 9'h1E1);
        if1.d  = 9'h100;
        @(posedge clk);
        #1 check("s1_last_d_wins", if1.q, 9'h100);
        step1(1'b0, 1'b1, 9'h001);
        check("s1_lsb_exact", if1.q, 9'h001);

        // Three-stage chain: reset value on every stage for STAGES edges.
        rst1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step3(1'b1, 1'b1, 9'h1FF);
            check("s3_reset_val", if3.q, 9'h0AA);
        end
        step3(1'b0, 1'b1, 9'h123);
        check("s3_lat_edge1", if3.q, 9'h0AA);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_lat_edge2", if3.q, 9'h0AA);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_lat_edge3", if3.q, 9'h123);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_lat_edge4", if3.q, 9'h000);

        // Enable low freezes the whole chain mid-flight.
        step3(1'b0, 1'b1, 9'h07E);
        step3(1'b0, 1'b0, 9'h1FF);
        step3(1'b0, 1'b0, 9'h1FF);
        check("s3_hold_q", if3.q, 9'h000);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_resume_edge2", if3.q, 9'h000);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_resume_edge3", if3.q, 9'h07E);

        // Reset with data in flight: nothing from before reset may reach q.
        step3(1'b0, 1'b1, 9'h1FF);
        step3(1'b0, 1'b1, 9'h1FE);
        step3(1'b1, 1'b1, 9'h1FD);
        check("s3_flush_reset", if3.q, 9'h0AA);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_flush_edge1", if3.q, 9'h0AA);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_flush_edge2", if3.q, 9'h0AA);
        step3(1'b0, 1'b1, 9'h000);
        check("s3_flush_edge3", if3.q, 9'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
